// File: rtl/assert_collector.sv
// Self-check result collector: counts passing/failing checks, drives a sticky
// ERROR flag and keeps a small FIFO of the first failing check IDs.
module assert_collector #(
    parameter int ID_W      = 8,
    parameter int CNT_W     = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         finish,
    input  logic                         chk_valid,
    output logic                         chk_ready,
    input  logic                         chk_pass,
    input  logic [ID_W-1:0]              chk_id,
    output logic                         ERROR,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             pass_cnt,
    output logic [CNT_W-1:0]             fail_cnt,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    input  logic                         log_rd_en,
    output logic                         log_rd_valid,
    output logic [ID_W-1:0]              log_rd_id
);

    localparam int PTR_W  = $clog2(LOG_DEPTH);
    localparam int LCNT_W = PTR_W + 1;
    localparam logic [LCNT_W-1:0] LOG_FULL = LCNT_W'(LOG_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              error_q, error_d;
    logic              log_overflow_q, log_overflow_d;
    logic [LCNT_W-1:0] log_count_q, log_count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              log_rd_valid_q, log_rd_valid_d;
    logic [ID_W-1:0]   log_rd_id_q, log_rd_id_d;
    logic [ID_W-1:0]   mem_q [LOG_DEPTH];
    logic [ID_W-1:0]   mem_d [LOG_DEPTH];

    logic accept;
    logic enter_run;
    logic push;
    logic pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (finish) state_d = DONE;
            DONE:    if (start)  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        chk_ready = (state_q == RUN);
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
    end

    // Push and pop live in different states, so they never coincide.
    always_comb begin
        accept    = (state_q == RUN) && chk_valid;
        enter_run = start && (state_q != RUN);
        push      = accept && !chk_pass && (log_count_q < LOG_FULL);
        pop       = (state_q == DONE) && log_rd_en && (log_count_q != '0);
    end

    always_comb begin
        pass_cnt_d     = pass_cnt_q;
        fail_cnt_d     = fail_cnt_q;
        error_d        = error_q;
        log_overflow_d = log_overflow_q;
        log_count_d    = log_count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        mem_d          = mem_q;
        log_rd_valid_d = pop;
        log_rd_id_d    = pop ? mem_q[rd_ptr_q] : log_rd_id_q;

        if (enter_run) begin
            pass_cnt_d     = '0;
            fail_cnt_d     = '0;
            error_d        = 1'b0;
            log_overflow_d = 1'b0;
            log_count_d    = '0;
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
        end else if (accept) begin
            if (chk_pass) begin
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                error_d = 1'b1;
                if (push) begin
                    mem_d[wr_ptr_q] = chk_id;
                    wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                    log_count_d     = log_count_q + LCNT_W'(1);
                end else begin
                    log_overflow_d = 1'b1;
                end
            end
        end else if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            log_count_d = log_count_q - LCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q     <= '0;
            fail_cnt_q     <= '0;
            error_q        <= 1'b0;
            log_overflow_q <= 1'b0;
            log_count_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            log_rd_valid_q <= 1'b0;
            log_rd_id_q    <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pass_cnt_q     <= pass_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
            error_q        <= error_d;
            log_overflow_q <= log_overflow_d;
            log_count_q    <= log_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            log_rd_valid_q <= log_rd_valid_d;
            log_rd_id_q    <= log_rd_id_d;
            for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;
    assign ERROR        = error_q;
    assign log_overflow = log_overflow_q;
    assign log_count    = log_count_q;
    assign log_rd_valid = log_rd_valid_q;
    assign log_rd_id    = log_rd_id_q;

endmodule

// File: tb/tb_assert_collector.sv
// Bench for assert_collector: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_assert_collector;

    localparam int ID_W      = 8;
    localparam int CNT_W     = 4;
    localparam int LOG_DEPTH = 4;
    localparam int CNT_SAT   = 15;

    logic            clk;
    logic            rst;
    logic            start;
    logic            finish;
    logic            chk_valid;
    logic            chk_ready;
    logic            chk_pass;
    logic [ID_W-1:0] chk_id;
    logic            ERROR;
    logic            busy;
    logic            done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [2:0]      log_count;
    logic            log_overflow;
    logic            log_rd_en;
    logic            log_rd_valid;
    logic [ID_W-1:0] log_rd_id;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0=IDLE 1=RUN 2=DONE
    int       m_mode;
    int       m_pass;
    int       m_fail;
    bit       m_err;
    bit       m_ovf;
    bit       m_rdv;
    int       m_rdid;
    int       m_log[$];

    assert_collector #(.ID_W(ID_W), .CNT_W(CNT_W), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_pass(chk_pass),
        .chk_id(chk_id), .ERROR(ERROR), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .log_count(log_count),
        .log_overflow(log_overflow), .log_rd_en(log_rd_en),
        .log_rd_valid(log_rd_valid), .log_rd_id(log_rd_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_mode = 0; m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0;
        m_rdv = 0; m_rdid = 0;
        m_log.delete();
    endtask

    task automatic modelEdge();
        int cur = m_mode;
        m_rdv = 0;
        if (cur == 2 && log_rd_en && m_log.size() > 0) begin
            m_rdv  = 1;
            m_rdid = m_log.pop_front();
        end
        if (cur == 1 && chk_valid) begin
            if (chk_pass) begin
                if (m_pass < CNT_SAT) m_pass++;
            end else begin
                if (m_fail < CNT_SAT) m_fail++;
                m_err = 1;
                if (m_log.size() < LOG_DEPTH) m_log.push_back(int'(chk_id));
                else m_ovf = 1;
            end
        end
        if (cur != 1 && start) begin
            m_mode = 1; m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0;
            m_log.delete();
        end else if (cur == 1 && finish) begin
            m_mode = 2;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".chk_ready"},    32'(chk_ready),    32'(m_mode == 1));
        checkVal({tag, ".busy"},         32'(busy),         32'(m_mode == 1));
        checkVal({tag, ".done"},         32'(done),         32'(m_mode == 2));
        checkVal({tag, ".ERROR"},        32'(ERROR),        32'(m_err));
        checkVal({tag, ".pass_cnt"},     32'(pass_cnt),     32'(m_pass));
        checkVal({tag, ".fail_cnt"},     32'(fail_cnt),     32'(m_fail));
        checkVal({tag, ".log_count"},    32'(log_count),    32'(m_log.size()));
        checkVal({tag, ".log_overflow"}, 32'(log_overflow), 32'(m_ovf));
        checkVal({tag, ".log_rd_valid"}, 32'(log_rd_valid), 32'(m_rdv));
        checkVal({tag, ".log_rd_id"},    32'(log_rd_id),    32'(m_rdid));
    endtask

    task automatic applyStimulus(input bit s, input bit f, input bit v, input bit p,
                                 input int id, input bit rd);
        start     = s;
        finish    = f;
        chk_valid = v;
        chk_pass  = p;
        chk_id    = ID_W'(id);
        log_rd_en = rd;
    endtask

    task automatic runCycle(input string tag, input bit s, input bit f, input bit v,
                            input bit p, input int id, input bit rd);
        applyStimulus(s, f, v, p, id, rd);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2;
        doReset();

        // Basic run: two passes, one fail, then read the logged ID back.
        runCycle("t1.start", 1, 0, 0, 0, 0, 0);
        runCycle("t1.p1",    0, 0, 1, 1, 1, 0);
        runCycle("t1.p2",    0, 0, 1, 1, 2, 0);
        runCycle("t1.f7",    0, 0, 1, 0, 7, 0);
        runCycle("t1.fin",   0, 1, 0, 0, 0, 0);
        checkVal("t1.pass_cnt", 32'(pass_cnt), 2);
        checkVal("t1.fail_cnt", 32'(fail_cnt), 1);
        checkVal("t1.ERROR",    32'(ERROR), 1);
        checkVal("t1.log_count", 32'(log_count), 1);
        checkVal("t1.done",     32'(done), 1);
        runCycle("t1.pop",   0, 0, 0, 0, 0, 1);
        checkVal("t1.rd_valid", 32'(log_rd_valid), 1);
        checkVal("t1.rd_id",    32'(log_rd_id), 7);
        runCycle("t1.idle",  0, 0, 0, 0, 0, 0);
        checkVal("t1.rd_valid_drop", 32'(log_rd_valid), 0);

        // Log overflow: six failures into a four-deep log.
        runCycle("t2.start", 1, 0, 0, 0, 0, 0);
        checkVal("t2.cleared_ERROR", 32'(ERROR), 0);
        for (int i = 10; i <= 15; i++) runCycle("t2.fail", 0, 0, 1, 0, i, 0);
        runCycle("t2.fin",   0, 1, 0, 0, 0, 0);
        checkVal("t2.fail_cnt",  32'(fail_cnt), 6);
        checkVal("t2.log_count", 32'(log_count), 4);
        checkVal("t2.overflow",  32'(log_overflow), 1);
        for (int i = 0; i < 4; i++) begin
            runCycle("t2.pop", 0, 0, 0, 0, 0, 1);
            checkVal("t2.pop_id", 32'(log_rd_id), 32'(10 + i));
            checkVal("t2.pop_valid", 32'(log_rd_valid), 1);
        end
        runCycle("t2.pop_empty", 0, 0, 0, 0, 0, 1);
        checkVal("t2.pop_empty_valid", 32'(log_rd_valid), 0);

        // Checks outside RUN are ignored; finish coincides with a fail.
        doReset();
        runCycle("t3.idle_v", 0, 0, 1, 0, 9, 0);
        runCycle("t3.idle_v", 0, 0, 1, 0, 9, 1);
        runCycle("t3.start",  1, 0, 1, 0, 9, 0);
        runCycle("t3.fin_f3", 0, 1, 1, 0, 3, 0);
        checkVal("t3.chk_ready", 32'(chk_ready), 0);
        runCycle("t3.done_v", 0, 0, 1, 0, 8, 0);
        runCycle("t3.done_v", 0, 0, 1, 1, 8, 0);
        checkVal("t3.fail_cnt", 32'(fail_cnt), 1);
        checkVal("t3.pass_cnt", 32'(pass_cnt), 0);
        runCycle("t3.pop",    0, 0, 0, 0, 0, 1);
        checkVal("t3.rd_id", 32'(log_rd_id), 3);

        // Restart from DONE with ERROR set, then saturate the pass counter.
        runCycle("t4.prep_f", 0, 0, 0, 0, 0, 0);
        checkVal("t4.ERROR_before", 32'(ERROR), 1);
        runCycle("t4.restart", 1, 0, 0, 0, 0, 0);
        checkVal("t4.ERROR",     32'(ERROR), 0);
        checkVal("t4.fail_cnt",  32'(fail_cnt), 0);
        checkVal("t4.log_count", 32'(log_count), 0);
        for (int i = 0; i < 20; i++) runCycle("t4.pass", 0, 0, 1, 1, i, 0);
        checkVal("t4.pass_sat", 32'(pass_cnt), 15);
        checkVal("t4.ERROR_pass", 32'(ERROR), 0);

        // Asynchronous reset between edges while running.
        runCycle("t5.f1", 0, 0, 1, 0, 21, 0);
        runCycle("t5.f2", 0, 0, 1, 0, 22, 0);
        checkVal("t5.fail_cnt", 32'(fail_cnt), 2);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("t5.async");
        checkVal("t5.busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            runCycle("rand",
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) != 0,
                     int'($urandom_range(0, 255)),
                     $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
